gumnut_control: RTL and testbench

GUMNUT_CONTROL -- requirements
Module: gumnut_control

---
 rtl/gumnut_control.sv | 165 ++++++++++++++++
 tb/tb_gumnut_control.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gumnut_control.sv
// Gumnut control unit: fetch/decode/execute sequencing, instruction decode,
// program counter and branch flags for an 18-bit Gumnut-style core.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH   | request instruction at pc, latch IR and bump pc on ack
// DECODE  | one-cycle settle of the latched instruction
// EXECUTE | decode outputs valid; flags, jumps and branches resolve
// MEM     | data/port access, held until data_ack_i
// WRITE   | one-cycle register-file write of the result
// HALT    | core stopped until reset
module gumnut_control (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [17:0] inst_i,
  input  logic        inst_ack_i,
  output logic        inst_stb_o,
  output logic [11:0] pc_o,
  input  logic        data_ack_i,
  output logic        data_stb_o,
  output logic        data_we_o,
  output logic        port_o,
  input  logic        carry_i,
  input  logic        zero_i,
  output logic [3:0]  ALUOp_o,
  output logic [2:0]  count_o,
  output logic        op2_sel_o,
  output logic [7:0]  imm_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs_o,
  output logic [2:0]  rs2_o,
  output logic        reg_we_o,
  output logic        wb_sel_o,
  output logic        halted_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITE,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] ir_q;
  logic [11:0] pc_q;
  logic        z_q, c_q;

  logic        is_alui, is_mem, is_shift, is_alur, is_jmp, is_br, is_halt;
  logic [1:0]  mem_fn;
  logic        mem_load;
  logic        br_taken;
  logic [11:0] br_target;

  // Instruction class is fixed by the leading-ones prefix of IR.
  assign is_alui  = ~ir_q[17];
  assign is_mem   = (ir_q[17:16] == 2'b10);
  assign is_shift = (ir_q[17:15] == 3'b110);
  assign is_alur  = (ir_q[17:14] == 4'b1110);
  assign is_jmp   = (ir_q[17:13] == 5'b11110);
  assign is_br    = (ir_q[17:12] == 6'b111110);
  assign is_halt  = (ir_q[17:12] == 6'b111111);

  // mem fn: bit0 selects store direction, bit1 selects the I/O port space.
  assign mem_fn   = ir_q[15:14];
  assign mem_load = ~mem_fn[0];

  // pc has already been incremented past the branch when this is used.
  assign br_target = pc_q + {{4{ir_q[7]}}, ir_q[7:0]};

  // Branch condition evaluated on the flags stored by the last ALU/shift op.
  always_comb begin
    br_taken = 1'b0;
    case (ir_q[11:10])
      2'b00:   br_taken = z_q;
      2'b01:   br_taken = ~z_q;
      2'b10:   br_taken = c_q;
      default: br_taken = ~c_q;
    endcase
  end

  // State, IR, pc and flag registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= 12'd0;
      ir_q    <= 18'd0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && inst_ack_i) begin
        ir_q <= inst_i;
        pc_q <= pc_q + 12'd1;
      end
      if (state_q == S_EXECUTE) begin
        if (is_alui || is_alur || is_shift) begin
          z_q <= zero_i;
          c_q <= carry_i;
        end
        if (is_jmp) begin
          pc_q <= ir_q[11:0];
        end else if (is_br && br_taken) begin
          pc_q <= br_target;
        end
      end
    end
  end

  // Next-state logic and state-decoded strobes/enables.
  always_comb begin
    state_d    = state_q;
    inst_stb_o = 1'b0;
    data_stb_o = 1'b0;
    data_we_o  = 1'b0;
    port_o     = 1'b0;
    reg_we_o   = 1'b0;
    halted_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        inst_stb_o = 1'b1;
        if (inst_ack_i) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (is_halt)                            state_d = S_HALT;
        else if (is_mem)                        state_d = S_MEM;
        else if (is_jmp || is_br)               state_d = S_FETCH;
        else                                    state_d = S_WRITE;
      end
      S_MEM: begin
        data_stb_o = 1'b1;
        data_we_o  = mem_fn[0];
        port_o     = mem_fn[1];
        if (data_ack_i) state_d = mem_load ? S_WRITE : S_FETCH;
      end
      S_WRITE: begin
        reg_we_o = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Field decode straight from IR; only meaningful once IR holds the instruction.
  always_comb begin
    ALUOp_o = 4'b0000;
    if (is_alui)       ALUOp_o = {1'b0, ir_q[16:14]};
    else if (is_alur)  ALUOp_o = {1'b0, ir_q[2:0]};
    else if (is_shift) ALUOp_o = {2'b10, ir_q[1:0]};
  end

  assign op2_sel_o = is_alui | is_mem;
  assign imm_o     = ir_q[7:0];
  assign count_o   = ir_q[7:5];
  assign rd_o      = ir_q[13:11];
  assign rs_o      = ir_q[10:8];
  assign rs2_o     = ir_q[7:5];
  assign wb_sel_o  = is_mem & mem_load;
  assign pc_o      = pc_q;

endmodule

// File: tb/tb_gumnut_control.sv
// Bench for gumnut_control: an instruction-level model expands each directed
// instruction into its expected per-cycle bus activity; one compare process
// checks the DUT against that plan every cycle, plus literal spot checks.
module tb_gumnut_control;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [17:0] inst_i = '0;
  logic        inst_ack_i = 1'b0;
  logic        inst_stb_o;
  logic [11:0] pc_o;
  logic        data_ack_i = 1'b0;
  logic        data_stb_o, data_we_o, port_o;
  logic        carry_i = 1'b0, zero_i = 1'b0;
  logic [3:0]  ALUOp_o;
  logic [2:0]  count_o;
  logic        op2_sel_o;
  logic [7:0]  imm_o;
  logic [2:0]  rd_o, rs_o, rs2_o;
  logic        reg_we_o, wb_sel_o, halted_o;

  gumnut_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .inst_ack_i(inst_ack_i),
    .inst_stb_o(inst_stb_o), .pc_o(pc_o), .data_ack_i(data_ack_i),
    .data_stb_o(data_stb_o), .data_we_o(data_we_o), .port_o(port_o),
    .carry_i(carry_i), .zero_i(zero_i), .ALUOp_o(ALUOp_o), .count_o(count_o),
    .op2_sel_o(op2_sel_o), .imm_o(imm_o), .rd_o(rd_o), .rs_o(rs_o),
    .rs2_o(rs2_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst, iack, dack, z, c;
    logic [17:0] inst;
    bit          chk;
    bit          e_istb, e_dstb, e_we, e_port, e_rwe, e_halt;
    logic [11:0] e_pc;
    bit          chk_wb;  bit e_wb; logic [2:0] e_rd;
    bit          chk_alu; logic [3:0] e_aluop;
    bit          chk_op2; bit e_op2;
    bit          chk_imm; logic [7:0] e_imm;
    bit          chk_regs; logic [2:0] e_rs;
    bit          chk_rs2; logic [2:0] e_rs2;
    bit          chk_cnt; logic [2:0] e_cnt;
    int          lit;
  } cyc_t;

  cyc_t        plan[$];
  cyc_t        cr;
  int          cur = 0;
  bit          running = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [11:0] m_pc = '0;
  bit          m_z = 1'b0, m_c = 1'b0;
  int          pending_lit = 0;
  int          last_len = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at step %0d: got %0h expected %0h", nm, cur, act, exp);
    end
  endtask

  function automatic cyc_t base(input logic [17:0] inst, input bit z, input bit c, input bit noise);
    cyc_t r;
    r = '{default: 0};
    r.inst = inst; r.z = z; r.c = c; r.chk = 1'b1;
    r.iack = noise; r.dack = noise;
    r.e_pc = m_pc;
    return r;
  endfunction

  task automatic push(input cyc_t r);
    if (pending_lit != 0) begin
      r.lit = pending_lit;
      pending_lit = 0;
    end
    plan.push_back(r);
  endtask

  task automatic do_reset(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r = '{default: 0};
      r.rst = 1'b1;
      push(r);
    end
    m_pc = '0; m_z = 1'b0; m_c = 1'b0;
  endtask

  // One instruction: fetch (iwait stall cycles), decode, execute, then its tail.
  task automatic step(input logic [17:0] inst, input int iwait, input int dwait,
                      input bit z, input bit c, input bit noise, input bit abort,
                      input int lit_ex, input int lit_last, input int lit_next);
    cyc_t r;
    int   n0, cls, fn, disp;
    bit   taken;
    n0 = plan.size();
    for (int w = 0; w <= iwait; w++) begin
      r = base(inst, z, c, noise);
      r.iack = (w == iwait);
      r.e_istb = 1'b1;
      push(r);
    end
    m_pc = 12'((int'(m_pc) + 1) % 4096);
    r = base(inst, z, c, noise);
    push(r);

    if ((inst >> 17) == 0)       cls = 0;
    else if ((inst >> 16) == 2)  cls = 1;
    else if ((inst >> 15) == 6)  cls = 2;
    else if ((inst >> 14) == 14) cls = 3;
    else if ((inst >> 13) == 30) cls = 4;
    else if ((inst >> 12) == 62) cls = 5;
    else                         cls = 6;

    r = base(inst, z, c, noise);
    r.lit = lit_ex;
    r.e_rs = 3'((inst >> 8) & 18'd7);
    r.e_imm = 8'(inst & 18'd255);
    case (cls)
      0: begin r.chk_alu = 1; r.e_aluop = 4'((inst >> 14) & 18'd7);
               r.chk_op2 = 1; r.e_op2 = 1; r.chk_imm = 1; r.chk_regs = 1; end
      1: begin r.chk_alu = 1; r.e_aluop = 4'd0;
               r.chk_op2 = 1; r.e_op2 = 1; r.chk_imm = 1; r.chk_regs = 1; end
      2: begin r.chk_alu = 1; r.e_aluop = 4'(8 + (inst & 18'd3)); r.chk_regs = 1;
               r.chk_cnt = 1; r.e_cnt = 3'((inst >> 5) & 18'd7); end
      3: begin r.chk_alu = 1; r.e_aluop = 4'(inst & 18'd7); r.chk_op2 = 1; r.e_op2 = 0;
               r.chk_regs = 1; r.chk_rs2 = 1; r.e_rs2 = 3'((inst >> 5) & 18'd7); end
      default: ;
    endcase
    push(r);

    case (cls)
      0, 2, 3: begin
        m_z = z; m_c = c;
        r = base(inst, z, c, noise);
        r.e_rwe = 1; r.chk_wb = 1; r.e_wb = 0; r.e_rd = 3'((inst >> 11) & 18'd7);
        r.lit = lit_last;
        push(r);
      end
      1: begin
        fn = int'((inst >> 14) & 18'd3);
        for (int w = 0; w <= dwait; w++) begin
          r = base(inst, z, c, noise);
          r.dack = (w == dwait);
          r.e_dstb = 1; r.e_we = (fn == 1 || fn == 3); r.e_port = (fn >= 2);
          if (abort) begin r.rst = 1; r.dack = 0; end
          else if (w == dwait && (fn == 1 || fn == 3)) r.lit = lit_last;
          push(r);
          if (abort) break;
        end
        if (abort) begin
          m_pc = '0; m_z = 1'b0; m_c = 1'b0;
        end else if (fn == 0 || fn == 2) begin
          r = base(inst, z, c, noise);
          r.e_rwe = 1; r.chk_wb = 1; r.e_wb = 1; r.e_rd = 3'((inst >> 11) & 18'd7);
          r.lit = lit_last;
          push(r);
        end
      end
      4: m_pc = 12'(inst & 18'hFFF);
      5: begin
        fn = int'((inst >> 10) & 18'd3);
        taken = (fn == 0) ? m_z : (fn == 1) ? !m_z : (fn == 2) ? m_c : !m_c;
        disp = int'(inst & 18'd255);
        if (disp > 127) disp -= 256;
        if (taken) m_pc = 12'((int'(m_pc) + disp + 4096) % 4096);
      end
      default: begin
        for (int k = 0; k < 6; k++) begin
          r = base(inst, z, c, 1'b1);
          r.e_halt = 1; r.lit = 7;
          push(r);
        end
      end
    endcase
    pending_lit = lit_next;
    last_len = plan.size() - n0;
  endtask

  // Compare every cycle against the plan, then the literal spot checks.
  always @(negedge clk_i) begin
    if (running) begin
      cr = plan[cur];
      if (cr.chk) begin
        check("inst_stb", 32'(inst_stb_o), 32'(cr.e_istb));
        check("data_stb", 32'(data_stb_o), 32'(cr.e_dstb));
        check("data_we", 32'(data_we_o), 32'(cr.e_we));
        check("port", 32'(port_o), 32'(cr.e_port));
        check("reg_we", 32'(reg_we_o), 32'(cr.e_rwe));
        check("halted", 32'(halted_o), 32'(cr.e_halt));
        check("pc", 32'(pc_o), 32'(cr.e_pc));
        if (cr.chk_wb) begin
          check("wb_sel", 32'(wb_sel_o), 32'(cr.e_wb));
          check("rd", 32'(rd_o), 32'(cr.e_rd));
        end
        if (cr.chk_alu) check("aluop", 32'(ALUOp_o), 32'(cr.e_aluop));
        if (cr.chk_op2) check("op2_sel", 32'(op2_sel_o), 32'(cr.e_op2));
        if (cr.chk_imm) check("imm", 32'(imm_o), 32'(cr.e_imm));
        if (cr.chk_regs) check("rs", 32'(rs_o), 32'(cr.e_rs));
        if (cr.chk_rs2) check("rs2", 32'(rs2_o), 32'(cr.e_rs2));
        if (cr.chk_cnt) check("count", 32'(count_o), 32'(cr.e_cnt));
      end
      case (cr.lit)
        1: begin
          check("lit_add_aluop", 32'(ALUOp_o), 32'h0);
          check("lit_add_op2", 32'(op2_sel_o), 32'h1);
          check("lit_add_imm", 32'(imm_o), 32'h05);
          check("lit_add_rs", 32'(rs_o), 32'h2);
        end
        2: begin
          check("lit_add_we", 32'(reg_we_o), 32'h1);
          check("lit_add_rd", 32'(rd_o), 32'h1);
          check("lit_add_pc", 32'(pc_o), 32'h1);
        end
        3: check("lit_bz_pc", 32'(pc_o), 32'h000);
        4: check("lit_bnz_pc", 32'(pc_o), 32'h001);
        5: begin
          check("lit_ldm_we", 32'(reg_we_o), 32'h1);
          check("lit_ldm_rd", 32'(rd_o), 32'h3);
          check("lit_ldm_wb", 32'(wb_sel_o), 32'h1);
        end
        6: begin
          check("lit_abort_pc", 32'(pc_o), 32'h0);
          check("lit_abort_istb", 32'(inst_stb_o), 32'h1);
          check("lit_abort_dstb", 32'(data_stb_o), 32'h0);
          check("lit_abort_we", 32'(reg_we_o), 32'h0);
        end
        7: begin
          check("lit_halt", 32'(halted_o), 32'h1);
          check("lit_halt_istb", 32'(inst_stb_o), 32'h0);
        end
        default: ;
      endcase
    end
  end

  initial begin
    do_reset(2);
    step(18'h00A05, 0, 0, 0, 0, 0, 0, 1, 2, 0);   // add r1,r2,#5
    check("lat_alu", 32'(last_len), 32'd4);
    do_reset(1);
    step(18'h04901, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // sub, zero_i=1
    step(18'h3E0FE, 0, 0, 0, 0, 0, 0, 0, 0, 3);   // bz -2 at pc 1
    check("lat_branch", 32'(last_len), 32'd3);
    step(18'h393A3, 3, 0, 0, 1, 1, 0, 0, 0, 0);   // alu-reg, fetch stalled 3
    step(18'h325C2, 0, 0, 0, 1, 1, 0, 0, 0, 0);   // shift
    step(18'h3E803, 0, 0, 1, 0, 0, 0, 0, 0, 0);   // bc +3 (taken)
    step(18'h3EC05, 0, 0, 1, 1, 0, 0, 0, 0, 0);   // bnc +5 (not taken)
    step(18'h25122, 0, 1, 0, 0, 1, 0, 0, 0, 0);   // stm, one wait
    step(18'h2F8FF, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // out
    check("lat_store", 32'(last_len), 32'd4);
    step(18'h2AE01, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // inp
    check("lat_load", 32'(last_len), 32'd5);
    step(18'h21C10, 0, 2, 0, 0, 0, 0, 0, 5, 0);   // ldm r3,(r4)+0x10
    step(18'h3CFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // jmp 0xFFF
    step(18'h3E401, 0, 0, 0, 0, 0, 0, 0, 0, 4);   // bnz +1 at 0xFFF
    step(18'h21C10, 0, 3, 0, 0, 0, 1, 0, 0, 6);   // ldm reset mid-MEM
    step(18'h00A05, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    step(18'h3F000, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // halt
    do_reset(1);
    step(18'h00A05, 1, 0, 0, 0, 0, 0, 1, 2, 0);

    running = 1'b1;
    for (int i = 0; i < plan.size(); i++) begin
      cur = i;
      rst_i = plan[i].rst;
      inst_i = plan[i].inst;
      inst_ack_i = plan[i].iack;
      data_ack_i = plan[i].dack;
      zero_i = plan[i].z;
      carry_i = plan[i].c;
      @(posedge clk_i);
      #1;
    end
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
